dcache_dm: RTL and testbench



---
 rtl/dcache_pkg.sv | 53 +++++
 rtl/dcache_dm_if.sv | 25 ++
 rtl/dcache_line_ram.sv | 68 ++++++
 rtl/dcache_dm.sv | 219 +++++++++++++++++++++
 tb/tb_dcache_dm.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped L1 data cache.
//   mem_type_t     : access size encoding shared with the MEM stage and SRAM
//   dcache_state_t : cache controller states
//   *_bits()       : address-field width helpers
//   be_of()        : byte-enable generation, also used by the store buffer
package dcache_pkg;

   typedef enum logic [1:0] {
      MEM_BYTE = 2'd0,
      MEM_HALF = 2'd1,
      MEM_WORD = 2'd2
   } mem_type_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_REFILL,
      S_WRITE,
      S_UNCACHED
   } dcache_state_t;

   // addr[31:29] value of the kseg1 (uncached) segment
   localparam logic [2:0] UNCACHED_SEG_DEFAULT = 3'b101;

   function automatic int index_bits(input int sets);
      return $clog2(sets);
   endfunction

   // Number of address bits that select the word in a line (0 for 1-word lines)
   function automatic int word_bits(input int line_words);
      return $clog2(line_words);
   endfunction

   // Width of a word pointer register; never zero so it can always be declared
   function automatic int word_ptr_bits(input int line_words);
      return (line_words > 1) ? $clog2(line_words) : 1;
   endfunction

   function automatic int tag_bits(input int sets, input int line_words);
      return 32 - 2 - word_bits(line_words) - index_bits(sets);
   endfunction

   // Byte enables for an aligned access; halfword offsets have offset[0]=0
   function automatic logic [3:0] be_of(input mem_type_t mt, input logic [1:0] offset);
      logic [3:0] be;
      case (mt)
         MEM_BYTE: be = 4'b0001 << offset;
         MEM_HALF: be = 4'b0011 << offset;
         default:  be = 4'hF;
      endcase
      return be;
   endfunction

endpackage

// File: rtl/dcache_dm_if.sv
// Word-wide SRAM bus.
//   master_rw : drives req/we/addr/mem_type/dout, receives din/ok
//   slave_rw  : the SRAM side
// The master holds its request until ok=1; din is valid in the ok cycle.
interface sram_interface;

   logic                  req;
   logic                  we;
   logic [31:0]           addr;
   dcache_pkg::mem_type_t mem_type;
   logic [31:0]           dout;
   logic [31:0]           din;
   logic                  ok;

   modport master_rw (
      output req, we, addr, mem_type, dout,
      input  din, ok
   );

   modport slave_rw (
      input  req, we, addr, mem_type, dout,
      output din, ok
   );

endinterface

// File: rtl/dcache_line_ram.sv
// Line storage for the direct-mapped cache, held in flops.
//   rd_index/rd_word -> rd_valid, rd_tag, rd_data : combinational lookup
//   wr_en/wr_index/wr_word/wr_be/wr_data          : byte-enabled data write
//   tag_we/tag_data                               : write tag of wr_index, set valid
//   inval                                         : clear valid of wr_index
//   clear_valid                                   : clear every valid bit
// Only valid bits are reset; tag and data contents are don't-care until valid.
module dcache_line_ram #(
   parameter int SETS       = 64,
   parameter int LINE_WORDS = 4,
   parameter int IW         = 6,
   parameter int WW         = 2,
   parameter int TW         = 22
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clear_valid,
   input  logic [IW-1:0] rd_index,
   input  logic [WW-1:0] rd_word,
   output logic          rd_valid,
   output logic [TW-1:0] rd_tag,
   output logic [31:0]   rd_data,
   input  logic          wr_en,
   input  logic [IW-1:0] wr_index,
   input  logic [WW-1:0] wr_word,
   input  logic [3:0]    wr_be,
   input  logic [31:0]   wr_data,
   input  logic          tag_we,
   input  logic          inval,
   input  logic [TW-1:0] tag_data
);

   logic [SETS-1:0] valid;
   logic [TW-1:0]   tag_arr  [SETS];
   logic [31:0]     data_arr [SETS][LINE_WORDS];

   assign rd_valid = valid[rd_index];
   assign rd_tag   = tag_arr[rd_index];
   assign rd_data  = data_arr[rd_index][rd_word];

   always_ff @(posedge clk) begin
      if (!rst_n || clear_valid) begin
         valid <= '0;
      end else if (tag_we) begin
         valid[wr_index] <= 1'b1;
      end else if (inval) begin
         valid[wr_index] <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (tag_we) begin
         tag_arr[wr_index] <= tag_data;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         always_ff @(posedge clk) begin
            if (wr_en && wr_be[gi]) begin
               data_arr[wr_index][wr_word][gi*8 +: 8] <= wr_data[gi*8 +: 8];
            end
         end
      end
   endgenerate

endmodule

// File: rtl/dcache_dm.sv
// Direct-mapped, write-through, no-write-allocate L1 data cache.
//   clk, rst_n (sync, active-low)
//   addr/req/we/mem_type/write_data : load/store request from the MEM stage
//   flush                           : invalidate all lines (taken only in IDLE)
//   ok/read_data                    : completion and aligned load word
//   sram_port                       : word-wide SRAM master used for line
//                                     refills, write-through and kseg1 accesses
module dcache_dm
   import dcache_pkg::*;
#(
   parameter int         SETS         = 64,
   parameter int         LINE_WORDS   = 4,
   parameter logic [2:0] UNCACHED_SEG = UNCACHED_SEG_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [31:0]      addr,
   input  logic             req,
   input  logic             we,
   input  mem_type_t        mem_type,
   input  logic [31:0]      write_data,
   input  logic             flush,
   output logic             ok,
   output logic [31:0]      read_data,
   sram_interface.master_rw sram_port
);

   localparam int IW = index_bits(SETS);
   localparam int WB = word_bits(LINE_WORDS);
   localparam int WW = word_ptr_bits(LINE_WORDS);
   localparam int TW = tag_bits(SETS, LINE_WORDS);
   localparam logic [31:0]   LINE_MASK = 32'(LINE_WORDS * 4 - 1);
   localparam logic [WW-1:0] LAST_WORD = WW'(LINE_WORDS - 1);

   dcache_state_t state;
   logic [WW-1:0] cnt;

   // address split
   logic [1:0]    offset;
   logic [WW-1:0] word;
   logic [IW-1:0] index;
   logic [TW-1:0] tag;
   logic          uncached;

   assign offset   = addr[1:0];
   assign word     = WW'((addr >> 2) & 32'(LINE_WORDS - 1));
   assign index    = IW'(addr >> (2 + WB));
   assign tag      = TW'(addr >> (2 + WB + IW));
   assign uncached = (addr[31:29] == UNCACHED_SEG);

   // line storage
   logic          line_valid;
   logic [TW-1:0] line_tag;
   logic [31:0]   line_word;
   logic          hit;
   logic          wr_en;
   logic [WW-1:0] wr_word;
   logic [3:0]    wr_be;
   logic [31:0]   wr_data;
   logic          tag_we;
   logic          inval;
   logic          clear_valid;

   assign hit = line_valid && (line_tag == tag) && !uncached;

   dcache_line_ram #(
      .SETS       (SETS),
      .LINE_WORDS (LINE_WORDS),
      .IW         (IW),
      .WW         (WW),
      .TW         (TW)
   ) u_line_ram (
      .clk         (clk),
      .rst_n       (rst_n),
      .clear_valid (clear_valid),
      .rd_index    (index),
      .rd_word     (word),
      .rd_valid    (line_valid),
      .rd_tag      (line_tag),
      .rd_data     (line_word),
      .wr_en       (wr_en),
      .wr_index    (index),
      .wr_word     (wr_word),
      .wr_be       (wr_be),
      .wr_data     (wr_data),
      .tag_we      (tag_we),
      .inval       (inval),
      .tag_data    (tag)
   );

   // Outputs and array controls. Hits and SRAM completions must answer in the
   // same cycle, so these are decoded from the current state.
   always_comb begin
      ok                 = 1'b0;
      read_data          = sram_port.din;
      sram_port.req      = 1'b0;
      sram_port.we       = 1'b0;
      sram_port.addr     = '0;
      sram_port.mem_type = MEM_WORD;
      sram_port.dout     = '0;
      wr_en              = 1'b0;
      wr_word            = word;
      wr_be              = be_of(mem_type, offset);
      wr_data            = write_data;
      tag_we             = 1'b0;
      inval              = 1'b0;
      clear_valid        = 1'b0;

      case (state)
         S_IDLE: begin
            if (hit) begin
               read_data = line_word;
            end
            if (flush) begin
               clear_valid = 1'b1;
            end else if (!req) begin
               ok = 1'b1;
            end else if (!uncached && !we) begin
               if (hit) begin
                  ok = 1'b1;
               end else begin
                  // a tag-mismatched line is dropped before its words are overwritten
                  inval = 1'b1;
               end
            end
         end

         S_REFILL: begin
            sram_port.req  = 1'b1;
            sram_port.addr = (addr & ~LINE_MASK) | (32'(cnt) << 2);
            if (sram_port.ok) begin
               wr_en   = 1'b1;
               wr_word = cnt;
               wr_be   = 4'hF;
               wr_data = sram_port.din;
               tag_we  = (cnt == LAST_WORD);
            end
         end

         S_WRITE: begin
            sram_port.req      = 1'b1;
            sram_port.we       = 1'b1;
            sram_port.addr     = addr;
            sram_port.mem_type = mem_type;
            sram_port.dout     = write_data;
            if (sram_port.ok) begin
               ok    = 1'b1;
               wr_en = hit;
            end
         end

         S_UNCACHED: begin
            sram_port.req      = 1'b1;
            sram_port.we       = we;
            sram_port.addr     = addr;
            sram_port.mem_type = mem_type;
            sram_port.dout     = write_data;
            ok                 = sram_port.ok;
         end

         default: ;
      endcase

      // Reset overrides immediately so an in-flight refill drops its request
      // in the reset cycle itself.
      if (!rst_n) begin
         ok                 = !req;
         read_data          = '0;
         sram_port.req      = 1'b0;
         sram_port.we       = 1'b0;
         sram_port.addr     = '0;
         sram_port.mem_type = MEM_WORD;
         sram_port.dout     = '0;
         wr_en              = 1'b0;
         tag_we             = 1'b0;
         inval              = 1'b0;
         clear_valid        = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= S_IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (!flush && req) begin
                  if (uncached) begin
                     state <= S_UNCACHED;
                  end else if (we) begin
                     state <= S_WRITE;
                  end else if (!hit) begin
                     state <= S_REFILL;
                     cnt   <= '0;
                  end
               end
            end
            S_REFILL: begin
               if (sram_port.ok) begin
                  if (cnt == LAST_WORD) begin
                     state <= S_IDLE;
                     cnt   <= '0;
                  end else begin
                     cnt <= cnt + WW'(1);
                  end
               end
            end
            S_WRITE, S_UNCACHED: begin
               if (sram_port.ok) begin
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dcache_dm.sv
// Self-checking bench for dcache_dm: a table of directed accesses against an
// SRAM model with two wait cycles, plus flush and reset-during-refill sequences.
module tb_dcache_dm;
   import dcache_pkg::*;

   localparam int LAT = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] addr;
   logic        req;
   logic        we;
   mem_type_t   mem_type;
   logic [31:0] write_data;
   logic        flush;
   logic        ok;
   logic [31:0] read_data;

   sram_interface sif ();

   dcache_dm dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .addr       (addr),
      .req        (req),
      .we         (we),
      .mem_type   (mem_type),
      .write_data (write_data),
      .flush      (flush),
      .ok         (ok),
      .read_data  (read_data),
      .sram_port  (sif)
   );

   always #5 clk = ~clk;

   // ---------------- SRAM model ----------------
   logic [31:0] mem [2048];
   int          wait_cnt = 0;
   int          txn_count = 0;
   int          req_cycles = 0;
   logic [31:0] log_addr [256];
   logic        log_we   [256];
   mem_type_t   log_mt   [256];

   assign sif.ok  = sif.req && (wait_cnt == LAT);
   assign sif.din = mem[sif.addr[12:2]];

   function automatic logic [3:0] model_be(input mem_type_t mt, input logic [1:0] a);
      logic [3:0] be;
      case (mt)
         MEM_BYTE: case (a)
                      2'd0: be = 4'b0001;
                      2'd1: be = 4'b0010;
                      2'd2: be = 4'b0100;
                      default: be = 4'b1000;
                   endcase
         MEM_HALF: be = a[1] ? 4'b1100 : 4'b0011;
         default:  be = 4'b1111;
      endcase
      return be;
   endfunction

   initial begin
      for (int i = 0; i < 2048; i++) mem[i] = {16'(i), ~16'(i)};
      mem[16] = 32'h1111_2222;
      mem[17] = 32'h3333_4444;
      mem[18] = 32'h5555_6666;
      mem[19] = 32'h7777_8888;
   end

   always @(posedge clk) begin
      if (sif.req) req_cycles <= req_cycles + 1;
      if (sif.req && sif.ok) begin
         wait_cnt <= 0;
         log_addr[txn_count[7:0]] <= sif.addr;
         log_we[txn_count[7:0]]   <= sif.we;
         log_mt[txn_count[7:0]]   <= sif.mem_type;
         txn_count <= txn_count + 1;
         if (sif.we) begin
            for (int b = 0; b < 4; b++)
               if (model_be(sif.mem_type, sif.addr[1:0])[b])
                  mem[sif.addr[12:2]][b*8 +: 8] <= sif.dout[b*8 +: 8];
         end
      end else if (sif.req) begin
         wait_cnt <= wait_cnt + 1;
      end else begin
         wait_cnt <= 0;
      end
   end

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Waits for ok with req already driven; drops req after the ok edge.
   task automatic wait_ok(input string name, output logic [31:0] rdata, output int waits);
      bit timeout;
      timeout = 1'b0;
      waits   = 0;
      rdata   = '0;
      forever begin
         @(negedge clk);
         if (ok) begin
            rdata = read_data;
            break;
         end
         waits++;
         if (waits > 200) begin
            timeout = 1'b1;
            break;
         end
      end
      check({name, "_timeout"}, 32'(timeout), 32'd0);
      @(posedge clk);
      #1;
      req = 1'b0;
      we  = 1'b0;
   endtask

   task automatic start(input logic [31:0] a, input logic w, input mem_type_t mt,
                        input logic [31:0] wd);
      addr = a; we = w; mem_type = mt; write_data = wd; req = 1'b1;
   endtask

   typedef struct {
      string       name;
      logic [31:0] addr;
      logic        we;
      mem_type_t   mt;
      logic [31:0] wdata;
      logic        chk_data;
      logic [31:0] exp_data;
      int          exp_waits;
      int          exp_txns;
   } vec_t;

   vec_t vecs [16];

   initial begin
      logic [31:0] rd;
      int          waits;
      int          t0;
      int          r0;
      int          k;

      vecs[0]  = '{"ld40_miss",   32'h0000_0040, 1'b0, MEM_WORD, 32'h0,         1'b1, 32'h1111_2222, 13, 4};
      vecs[1]  = '{"ld44_hit",    32'h0000_0044, 1'b0, MEM_WORD, 32'h0,         1'b1, 32'h3333_4444, 0,  0};
      vecs[2]  = '{"sb45",        32'h0000_0045, 1'b1, MEM_BYTE, 32'h0000_AB00, 1'b0, 32'h0,         3,  1};
      vecs[3]  = '{"ld44_merged", 32'h0000_0044, 1'b0, MEM_WORD, 32'h0,         1'b1, 32'h3333_AB44, 0,  0};
      vecs[4]  = '{"sw1000",      32'h0000_1000, 1'b1, MEM_WORD, 32'hDEAD_BEEF, 1'b0, 32'h0,         3,  1};
      vecs[5]  = '{"ld1000_miss", 32'h0000_1000, 1'b0, MEM_WORD, 32'h0,         1'b1, 32'hDEAD_BEEF, 13, 4};
      vecs[6]  = '{"ld_unc_a",    32'hA000_0040, 1'b0, MEM_WORD, 32'h0,         1'b1, 32'h1111_2222, 3,  1};
      vecs[7]  = '{"ld_unc_b",    32'hA000_0040, 1'b0, MEM_WORD, 32'h0,         1'b1, 32'h1111_2222, 3,  1};
      vecs[8]  = '{"ld40_hit",    32'h0000_0040, 1'b0, MEM_WORD, 32'h0,         1'b1, 32'h1111_2222, 0,  0};
      vecs[9]  = '{"sh4a",        32'h0000_004A, 1'b1, MEM_HALF, 32'hCAFE_0000, 1'b0, 32'h0,         3,  1};
      vecs[10] = '{"ld48_hit",    32'h0000_0048, 1'b0, MEM_WORD, 32'h0,         1'b1, 32'hCAFE_6666, 0,  0};
      vecs[11] = '{"ld104c_evict",32'h0000_104C, 1'b0, MEM_WORD, 32'h0,         1'b1, 32'h0413_FBEC, 13, 4};
      vecs[12] = '{"ld40_refill", 32'h0000_0040, 1'b0, MEM_WORD, 32'h0,         1'b1, 32'h1111_2222, 13, 4};
      vecs[13] = '{"ld48_hit2",   32'h0000_0048, 1'b0, MEM_WORD, 32'h0,         1'b1, 32'hCAFE_6666, 0,  0};
      vecs[14] = '{"sb_unc41",    32'hA000_0041, 1'b1, MEM_BYTE, 32'h0000_7700, 1'b0, 32'h0,         3,  1};
      vecs[15] = '{"ld40_stale",  32'h0000_0040, 1'b0, MEM_WORD, 32'h0,         1'b1, 32'h1111_2222, 0,  0};

      rst_n = 1'b0; req = 1'b0; we = 1'b0; mem_type = MEM_WORD;
      addr = '0; write_data = '0; flush = 1'b0;

      // reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_ok",        32'(ok),           32'd1);
      check("rst_read_data", read_data,         32'h0);
      check("rst_sram_req",  32'(sif.req),      32'd0);
      check("rst_sram_we",   32'(sif.we),       32'd0);
      check("rst_sram_addr", sif.addr,          32'h0);
      check("rst_sram_dout", sif.dout,          32'h0);
      check("rst_sram_mt",   32'(sif.mem_type), 32'(MEM_WORD));
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // table-driven accesses
      for (int i = 0; i < 16; i++) begin
         t0 = txn_count;
         r0 = req_cycles;
         start(vecs[i].addr, vecs[i].we, vecs[i].mt, vecs[i].wdata);
         wait_ok(vecs[i].name, rd, waits);
         if (vecs[i].chk_data) check({vecs[i].name, "_data"}, rd, vecs[i].exp_data);
         check({vecs[i].name, "_waits"}, 32'(waits), 32'(vecs[i].exp_waits));
         check({vecs[i].name, "_txns"}, 32'(txn_count - t0), 32'(vecs[i].exp_txns));
         check({vecs[i].name, "_reqcyc"}, 32'(req_cycles - r0), 32'(3 * vecs[i].exp_txns));
         if (vecs[i].exp_txns == 1) begin
            check({vecs[i].name, "_sram_addr"}, log_addr[t0[7:0]], vecs[i].addr);
            check({vecs[i].name, "_sram_we"}, 32'(log_we[t0[7:0]]), 32'(vecs[i].we));
            check({vecs[i].name, "_sram_mt"}, 32'(log_mt[t0[7:0]]), 32'(vecs[i].mt));
         end else if (vecs[i].exp_txns == 4) begin
            for (int w = 0; w < 4; w++) begin
               k = t0 + w;
               check($sformatf("%s_refill%0d_addr", vecs[i].name, w), log_addr[k[7:0]],
                     (vecs[i].addr & ~32'hF) + 32'(4 * w));
               check($sformatf("%s_refill%0d_mt", vecs[i].name, w), 32'(log_mt[k[7:0]]),
                     32'(MEM_WORD));
            end
         end
      end
      check("mem_after_sb_unc", mem[16], 32'h1111_7722);

      // flush together with a load of a resident line: flush wins, then refill
      t0 = txn_count;
      flush = 1'b1;
      start(32'h0000_0040, 1'b0, MEM_WORD, 32'h0);
      @(negedge clk);
      check("flush_cycle_ok", 32'(ok), 32'd0);
      @(posedge clk);
      #1;
      flush = 1'b0;
      wait_ok("flush_ld40", rd, waits);
      check("flush_ld40_data",  rd,                       32'h1111_7722);
      check("flush_ld40_waits", 32'(waits),               32'd13);
      check("flush_ld40_txns",  32'(txn_count - t0),      32'd4);

      // invalidate, then reset in the middle of a refill
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      t0 = txn_count;
      start(32'h0000_0040, 1'b0, MEM_WORD, 32'h0);
      k = 0;
      while ((txn_count - t0) < 2 && k < 100) begin
         @(posedge clk);
         #1;
         k++;
      end
      check("rstmid_two_words", 32'(txn_count - t0), 32'd2);
      rst_n = 1'b0;
      req   = 1'b0;
      @(negedge clk);
      check("rstmid_sram_req",  32'(sif.req),  32'd0);
      check("rstmid_read_data", read_data,     32'h0);
      check("rstmid_ok",        32'(ok),       32'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      t0 = txn_count;
      start(32'h0000_0040, 1'b0, MEM_WORD, 32'h0);
      wait_ok("rstmid_ld40", rd, waits);
      check("rstmid_ld40_data",  rd,                  32'h1111_7722);
      check("rstmid_ld40_waits", 32'(waits),          32'd13);
      check("rstmid_ld40_txns",  32'(txn_count - t0), 32'd4);
      t0 = txn_count;
      start(32'h0000_004C, 1'b0, MEM_WORD, 32'h0);
      wait_ok("rstmid_ld4c", rd, waits);
      check("rstmid_ld4c_data",  rd,                  32'h7777_8888);
      check("rstmid_ld4c_waits", 32'(waits),          32'd0);
      check("rstmid_ld4c_txns",  32'(txn_count - t0), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
